// File: rtl/ex_muldiv_pkg.sv
// Shared constants, encodings and helpers for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module ex_muldiv_step
    import ex_muldiv_pkg::*;
(
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    // Multiply: acc_hi is the partial product, acc_lo the multiplier shifting out.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    // Divide: acc_hi is the partial remainder, acc_lo the dividend becoming the quotient.
    // The remainder stays below the divisor, so the difference always fits in WIDTH bits.
    assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, operand};
    assign rem_sub   = rem_shift[WIDTH-1:0] - operand;

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        next_hi = mul_sum[WIDTH:1];
        next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            next_hi = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], rem_ge};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    op_e              op_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic             neg_q;
    logic             neg_r;

    op_e              op_in;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign op_in  = op_e'(op);
    assign sign_a = is_signed_op(op_in) & rs[WIDTH-1];
    assign sign_b = is_signed_op(op_in) & rt[WIDTH-1];
    assign busy   = (state != ST_IDLE) && (state != ST_DONE);

    ex_muldiv_step u_step (
        .is_div  (is_div_op(op_r)),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign correction: product negated as a whole; quotient and remainder independently.
    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        if (neg_q) prod_fix = -prod_fix;
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div_op(op_r)) begin
            fix_hi = neg_r ? -acc_hi : acc_hi;
            fix_lo = neg_q ? -acc_lo : acc_lo;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_r     <= OP_MULT;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r    <= op_in;
                        neg_q   <= sign_a ^ sign_b;
                        neg_r   <= sign_a;
                        cnt     <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= magnitude(rs, is_signed_op(op_in));
                        operand <= magnitude(rt, is_signed_op(op_in));
                        if (is_div_op(op_in) && (rt == '0)) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  request from EX stage: decoded mult/div from ID/EX control field, one-cycle pulse.
REQ-004 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 rs  input  32  operand A / dividend (forwarded ID/EX RS value); sampled with start.
REQ-006 rt  input  32  operand B / divisor (forwarded ID/EX RT value); sampled with start.
REQ-007 hi_we  input  1  MTHI write enable.
REQ-008 lo_we  input  1  MTLO write enable.
REQ-009 wdata  input  32  MTHI/MTLO data.
REQ-010 busy  output  1  operation in progress; pipeline stall request to ID/EX and earlier stages.
REQ-011 done  output  1  one-cycle pulse, HI/LO final this cycle.
REQ-012 div_zero  output  1  one-cycle pulse with done when DIV/DIVU had rt==0.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 States IDLE, RUN, FIX, DONE; reset state IDLE.
REQ-016 IDLE & start: latch op, |rs|, |rt| (magnitudes for signed ops, raw for unsigned), sign flags; iteration counter=0; next RUN.
REQ-017 RUN: one radix-2 step per cycle (shift-add multiply / restoring divide), 32 steps; after step 32 next FIX.
REQ-018 FIX: apply sign correction, write HI/LO; next DONE.
REQ-019 DONE: done=1 for exactly one cycle; next IDLE.
REQ-020 Timing: start sampled at edge 0 -> busy=1 for cycles 1..33 (RUN 32, FIX 1); done=1 and new HI/LO visible in cycle 34; busy=0 in DONE.
REQ-021 MULT/MULTU: {hi,lo} = 64-bit product, two's-complement for MULT.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
REQ-024 DIV/DIVU with rt==0: skip RUN/FIX, go IDLE->DONE; busy=0; HI/LO unchanged; done and div_zero pulse cycle 1.
REQ-025 start while not IDLE: ignored, operation continues unaffected.
REQ-026 hi_we/lo_we in IDLE without start: hi/lo <= wdata at next edge; both set writes both.
REQ-027 hi_we/lo_we while not IDLE: ignored.
REQ-028 start and hi_we/lo_we same IDLE cycle: start accepted, writes dropped.
REQ-029 hi/lo hold value at all times except REQ-018, REQ-026, reset.
REQ-030 Operand inputs may change after start without effect.

Reset
REQ-031 rst_n low at a rising edge: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div_zero=0.
REQ-032 Reset mid-operation aborts; no partial result written; no done pulse.
REQ-033 start asserted while rst_n low: ignored.

Structure
REQ-034 Shared package: op encodings, state encoding, ITER=32 constant, width constant 32.
REQ-035 One sub-module ex_muldiv_step: combinational single-iteration step (add/sub, shift) for both multiply and divide; FSM, counter, HI/LO registers live in ex_muldiv.
REQ-036 All outputs driven from registers except busy, which decodes state (not IDLE and not DONE).

Verification
REQ-037 MULT rs=0xFFFFFFFE (-2), rt=3 -> cycle 34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high cycles 1..33.
REQ-038 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU rs=7, rt=2 -> lo=3, hi=1.
REQ-040 DIV rt=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> cycle 1 done=1, div_zero=1, hi/lo unchanged, busy never high.
REQ-041 MULT started, rst_n low at cycle 10 -> cycle 11 IDLE, hi=lo=0, no done; second start and MTHI issued during busy ignored.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; back-to-back start in DONE cycle not accepted, accepted next cycle.
